// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Clocked ALU with a start/done handshake. Single-cycle ops (add, sub, and,
//   or, unsigned/signed set-greater-than) complete one edge after acceptance.
//   Right shifts iterate one bit per cycle and hold the unit busy meanwhile.
//   Result and overflow are registered and held until the next completion.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted on a rising edge while busy is low
//   op     in   [2:0] operation select, sampled at acceptance
//   a      in   [WIDTH-1:0] operand A, sampled at acceptance
//   b      in   [WIDTH-1:0] operand B / shift amount, sampled at acceptance
//   busy   out  high while an iterative shift is in progress
//   done   out  one-cycle completion pulse; c/ovf valid from this cycle
//   c      out  [WIDTH-1:0] registered result
//   zero   out  c == 0
//   ovf    out  registered signed overflow (ADD/SUB only, else 0)
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SRL  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;
    localparam logic [2:0] OP_SGTU = 3'b110;
    localparam logic [2:0] OP_SGT  = 3'b111;

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // Signed overflow of a+b: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a-b: operands differ in sign, result sign differs from a.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] c_r, c_s;
    logic             ovf_r, ovf_s;
    logic [WIDTH-1:0] sh_r, sh_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             fill_r, fill_s;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] shifted_s;
    logic [CW-1:0]    amt_s;
    logic             is_shift_s;

    assign sum_s     = a + b;
    assign diff_s    = a - b;
    // The full b is compared so large amounts saturate instead of wrapping.
    assign amt_s     = (b >= WIDTH_W) ? WIDTH_C : b[CW-1:0];
    assign shifted_s = {fill_r, sh_r[WIDTH-1:1]};
    assign is_shift_s = (op == OP_SRL) || (op == OP_SRA);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            c_r     <= ZERO_W;
            ovf_r   <= 1'b0;
            sh_r    <= ZERO_W;
            cnt_r   <= CNT_ZERO;
            fill_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            c_r     <= c_s;
            ovf_r   <= ovf_s;
            sh_r    <= sh_s;
            cnt_r   <= cnt_s;
            fill_r  <= fill_s;
        end
    end

    // Next-state and next-datapath logic; c/ovf only move on entry to DONE.
    always_comb begin
        state_s = state_r;
        c_s     = c_r;
        ovf_s   = ovf_r;
        sh_s    = sh_r;
        cnt_s   = cnt_r;
        fill_s  = fill_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && is_shift_s) begin
                    fill_s = (op == OP_SRA) ? a[WIDTH-1] : 1'b0;
                    if (amt_s == CNT_ZERO) begin
                        c_s     = a;
                        ovf_s   = 1'b0;
                        state_s = ST_DONE;
                    end else begin
                        sh_s    = a;
                        cnt_s   = amt_s;
                        state_s = ST_SHIFT;
                    end
                end else if (start) begin
                    ovf_s   = 1'b0;
                    state_s = ST_DONE;
                    case (op)
                        OP_ADD: begin
                            c_s   = sum_s;
                            ovf_s = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
                        end
                        OP_SUB: begin
                            c_s   = diff_s;
                            ovf_s = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_s[WIDTH-1]);
                        end
                        OP_AND:  c_s = a & b;
                        OP_OR:   c_s = a | b;
                        OP_SGTU: c_s = {{(WIDTH-1){1'b0}}, (a > b)};
                        OP_SGT:  c_s = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
                        default: c_s = ZERO_W;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sh_s  = shifted_s;
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    c_s     = shifted_s;
                    ovf_s   = 1'b0;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_r == ST_SHIFT);
    assign done = (state_r == ST_DONE);
    assign c    = c_r;
    assign ovf  = ovf_r;
    assign zero = (c_r == ZERO_W);

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Directed, table-driven bench for seq_alu. A 32-bit instance runs a vector
//   table plus hand-written sequences (ignored start while busy, back-to-back
//   ops, reset during a shift); an 8-bit instance covers the narrow corners.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, zero, ovf;
    logic [31:0] c;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, zero8, ovf8;
    logic [7:0]  c8;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] SRL = 3'd4, SRA = 3'd5, SGTU = 3'd6, SGT = 3'd7;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .c(c), .zero(zero), .ovf(ovf)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .c(c8), .zero(zero8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_c;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run32(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int busy_n, output int c_moved);
        logic [31:0] c0;
        c0 = c;
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        lat = 999; busy_n = 0; c_moved = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) begin
                busy_n++;
                if (c !== c0) c_moved = 1;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        output int lat);
        start8 = 1'b1; op8 = o; a8 = av; b8 = bv;
        @(posedge clk);
        lat = 999;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) start8 = 1'b0;
            if (done8) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, busy_n, c_moved, done_cnt, first_done;
        logic [31:0] c_at_done;

        vecs[0]  = '{ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1};
        vecs[1]  = '{SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 5};
        vecs[2]  = '{SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1};
        vecs[3]  = '{SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 5};
        vecs[4]  = '{SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1};
        vecs[5]  = '{SRL,  32'hFFFF_FFFF, 32'h0000_0028, 32'h0000_0000, 1'b0, 33};
        vecs[6]  = '{SRA,  32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 1'b0, 1};
        vecs[7]  = '{SGTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
        vecs[8]  = '{SGT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
        vecs[9]  = '{SGT,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
        vecs[10] = '{SGT,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1};
        vecs[11] = '{AND_, 32'hF0F0_A5A5, 32'h0FF0_FF00, 32'h00F0_A500, 1'b0, 1};
        vecs[12] = '{OR_,  32'hF0F0_0000, 32'h0000_A5A5, 32'hF0F0_A5A5, 1'b0, 1};
        vecs[13] = '{SRL,  32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_0000, 1'b0, 33};
        vecs[14] = '{SRA,  32'hC000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 32};
        vecs[15] = '{ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
        vecs[16] = '{SGT,  32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 1'b0, 1};
        vecs[17] = '{SRL,  32'h1234_5678, 32'h0000_0001, 32'h091A_2B3C, 1'b0, 2};
        vecs[18] = '{SGTU, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1};

        rst_n = 1'b0;
        start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        start8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_c",    {32'd0, c},    64'd0);
        check("rst_ovf",  {63'd0, ovf},  64'd0);
        check("rst_zero", {63'd0, zero}, 64'd1);
        check("rst_zero8", {63'd0, zero8}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 19; i++) begin
            run32(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_n, c_moved);
            check($sformatf("v%0d_c", i),    {32'd0, c},    {32'd0, vecs[i].exp_c});
            check($sformatf("v%0d_ovf", i),  {63'd0, ovf},  {63'd0, vecs[i].exp_ovf});
            check($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, (vecs[i].exp_c == 32'd0)});
            check($sformatf("v%0d_lat", i),  64'(lat),      64'(vecs[i].exp_lat));
            check($sformatf("v%0d_busy", i), 64'(busy_n),   64'(vecs[i].exp_lat - 1));
            check($sformatf("v%0d_hold", i), 64'(c_moved),  64'd0);
            @(negedge clk);
            check($sformatf("v%0d_done1", i), {63'd0, done}, 64'd0);
            check($sformatf("v%0d_held", i),  {32'd0, c},    {32'd0, vecs[i].exp_c});
        end

        // SRL by 8 with an ADD pulsed during the shift: the ADD is ignored.
        start = 1'b1; op = SRL; a = 32'hFF00_0000; b = 32'd8;
        @(posedge clk);
        done_cnt = 0; first_done = 0; busy_n = 0; c_at_done = 32'd0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b1; op = ADD; a = 32'd1; b = 32'd1;
            end else if (i == 2) begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = i;
                    c_at_done = c;
                end
            end
        end
        check("ign_done_cnt", 64'(done_cnt), 64'd1);
        check("ign_lat",      64'(first_done), 64'd9);
        check("ign_busy",     64'(busy_n), 64'd8);
        check("ign_c",        {32'd0, c_at_done}, 64'h00FF_0000);
        check("ign_c_held",   {32'd0, c}, 64'h00FF_0000);

        // Three back-to-back ADDs with start held high.
        start = 1'b1; op = ADD; a = 32'd1; b = 32'd2;
        @(posedge clk); @(negedge clk);
        check("b2b1_done", {63'd0, done}, 64'd1);
        check("b2b1_c",    {32'd0, c},    64'd3);
        a = 32'd10; b = 32'd20;
        @(posedge clk); @(negedge clk);
        check("b2b2_done", {63'd0, done}, 64'd1);
        check("b2b2_c",    {32'd0, c},    64'd30);
        a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF;
        @(posedge clk); @(negedge clk);
        check("b2b3_done", {63'd0, done}, 64'd1);
        check("b2b3_c",    {32'd0, c},    64'hFFFF_FFFE);
        check("b2b3_ovf",  {63'd0, ovf},  64'd1);
        start = 1'b0;
        @(negedge clk);
        check("b2b_end_done", {63'd0, done}, 64'd0);
        check("b2b_end_c",    {32'd0, c},    64'hFFFF_FFFE);

        // Reset in the middle of an SRA by 20.
        start = 1'b1; op = SRA; a = 32'h8000_0000; b = 32'd20;
        @(posedge clk);
        busy_n = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) busy_n++;
        end
        check("rsh_busy_before", 64'(busy_n), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        check("rsh_busy", {63'd0, busy}, 64'd0);
        check("rsh_done", {63'd0, done}, 64'd0);
        check("rsh_c",    {32'd0, c},    64'd0);
        check("rsh_ovf",  {63'd0, ovf},  64'd0);
        check("rsh_zero", {63'd0, zero}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rsh_no_done", {63'd0, done}, 64'd0);
        run32(AND_, 32'h0000_F0F0, 32'h0000_FF00, lat, busy_n, c_moved);
        check("rsh_and_c",   {32'd0, c}, 64'h0000_F000);
        check("rsh_and_lat", 64'(lat),   64'd1);
        @(negedge clk);

        // 8-bit instance corners.
        run8(ADD, 8'h7F, 8'h01, lat);
        check("w8_add_c",   {56'd0, c8},    64'h80);
        check("w8_add_ovf", {63'd0, ovf8},  64'd1);
        check("w8_add_lat", 64'(lat),       64'd1);
        @(negedge clk);
        run8(SRL, 8'hFF, 8'd200, lat);
        check("w8_srl_c",    {56'd0, c8},   64'h00);
        check("w8_srl_zero", {63'd0, zero8}, 64'd1);
        check("w8_srl_ovf",  {63'd0, ovf8}, 64'd0);
        check("w8_srl_lat",  64'(lat),      64'd9);
        @(negedge clk);
        run8(SRA, 8'h80, 8'd200, lat);
        check("w8_sra_c",   {56'd0, c8},    64'hFF);
        check("w8_sra_lat", 64'(lat),       64'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
